index_demux_dataless: RTL
=========================

// Module: index_demux_dataless
// PURPOSE
//  Dataless 1-to-SIZE demux steered by an index channel; the steering-side counterpart of a control merge.
//  Each control token on ins is routed to exactly one output, outs[k], where k is the next queued index.
//  An index FIFO lets indices run ahead of tokens; a one-slot output register breaks the valid path.
//  Sits where a control merge's index stream must re-split control flow, e.g. loop exits and branch replay.
// PARAMETERS
//  SIZE        2  number of output channels (>=2)
//  INDEX_TYPE  1  index width in bits; must satisfy 2**INDEX_TYPE >= SIZE
//  FIFO_DEPTH  4  index FIFO entries; power of 2, >=1
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  ins_valid    in   1           control token valid
//  ins_ready    out  1           control token ready
//  index        in   INDEX_TYPE  destination output number
//  index_valid  in   1           index valid
//  index_ready  out  1           index ready
//  outs_valid   out  SIZE        one-hot output valids
//  outs_ready   in   SIZE        output readies
//  err          out  1           sticky out-of-range flag; constant 0 unless INDEX_CHECK_EN is defined
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - FIFO pointers and count go to 0; out_v and err go to 0.
//   - While rst=1: ins_ready=0, index_ready=0, outs_valid=0.
//   - Reset mid-operation silently discards queued indices and any held token.
//  Index FIFO:
//   - rd/wr pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
//   - index_ready = !rst && count!=FIFO_DEPTH.
//   - Push on index_valid&&index_ready.
//   - No push-when-full even if a pop occurs that cycle (no ready comb path).
//   - Empty FIFO: no pop. No write-to-read bypass: an index pushed at cycle t is usable at t+1.
//   - Simultaneous push+pop leaves count unchanged.
//  Output register (state: out_v, sel[INDEX_TYPE]):
//   - Two states: EMPTY (out_v=0) and HELD (out_v=1).
//   - outs_valid[k] = out_v && sel==k; all bits are 0 when sel>=SIZE.
//   - drain = out_v && outs_ready[sel].
//   - ins_ready = !rst && count!=0 && (!out_v || drain).
//   - fire = ins_valid && ins_ready; fire pops the FIFO head into sel and sets out_v=1.
//   - HELD->EMPTY on drain without fire; HELD->HELD on drain with fire (back-to-back, 1 token/cycle).
//   - Latency: token accepted at t is visible on outs at t+1; outs_valid is never combinational from inputs.
//   - Held token is stable until its ready: sel and outs_valid do not change while out_v && !outs_ready[sel].
//  Out-of-range index (index>=SIZE, only possible when SIZE is not a power of 2):
//   - The token is still consumed and the index popped.
//   - out_v=1 with sel>=SIZE, so no output is raised; drain is forced to 1 for that slot, i.e. the token is dropped next cycle.
// CONFIGURATION
//  INDEX_CHECK_EN defined:
//   - err sets to 1 on the cycle after a fire that pops an index>=SIZE.
//   - err stays 1 until rst.
//  INDEX_CHECK_EN undefined:
//   - err tied to 0; out-of-range tokens are dropped silently.
//   - No extra state is generated.
// TESTING (SIZE=3, INDEX_TYPE=2, FIFO_DEPTH=4)
//  1. rst=1 for 2 cycles -> outs_valid=000, ins_ready=0, index_ready=0, err=0; cycle after release -> index_ready=1.
//  2. Push indices 2,0,1 with ins_valid=0, then ins_valid=1 and outs_ready=111
//     -> outs_valid=100,001,010 on 3 consecutive cycles, then 000.
//  3. Push 4 indices with ins_valid=0 -> index_ready=0 after the 4th.
//     Fire one token -> index_ready=1 the next cycle; count=3.
//  4. Index 1 held with outs_ready=101 -> outs_valid=010 held, ins_ready=0.
//     Raise outs_ready[1] with ins_valid=1 and next index 0 -> outs_valid=001 the next cycle.
//  5. Push index 3 and fire a token -> outs_valid stays 000, the token is consumed;
//     err=1 from the next cycle with INDEX_CHECK_EN, err=0 without.
//  6. Queue 2 indices, hold a token, assert rst one cycle -> after release: count=0, outs_valid=000,
//     and with ins_valid=1, ins_ready=0 until a new index is pushed.

Source files
------------

// File: rtl/index_demux_dataless.sv
// Dataless 1-to-SIZE demux: each control token goes to the output named by the next queued index.
// Optional sticky out-of-range flag when the INDEX_CHECK_EN macro is defined.
module index_demux_dataless #(
    parameter int SIZE       = 2,
    parameter int INDEX_TYPE = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [INDEX_TYPE-1:0] index,
    input  logic                  index_valid,
    output logic                  index_ready,
    output logic [SIZE-1:0]       outs_valid,
    input  logic [SIZE-1:0]       outs_ready,
    output logic                  err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    logic [INDEX_TYPE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    state_t                state_q, state_d;
    logic [INDEX_TYPE-1:0] sel_q, sel_d;

    logic                  out_v;
    logic                  ready_sel;
    logic                  drain;
    logic                  fire;
    logic                  push;
    logic [INDEX_TYPE-1:0] head;

    assign out_v       = (state_q == HELD);
    assign head        = mem_q[rd_ptr_q];
    assign index_ready = !rst && (count_q != FULL);
    assign push        = index_valid && index_ready;
    assign drain       = out_v && ready_sel;
    assign ins_ready   = !rst && (count_q != '0) && (!out_v || drain);
    assign fire        = ins_valid && ins_ready;

    // An out-of-range sel matches no output, so its ready defaults to 1 and the token drops.
    always_comb begin
        ready_sel = 1'b1;
        for (int k = 0; k < SIZE; k++) begin
            if (sel_q == INDEX_TYPE'(k)) ready_sel = outs_ready[k];
        end
    end

    always_comb begin
        outs_valid = '0;
        for (int k = 0; k < SIZE; k++) begin
            outs_valid[k] = !rst && out_v && (sel_q == INDEX_TYPE'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (fire) begin
            state_d = HELD;
            sel_d   = head;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (fire) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (push && !fire)      count_d = count_q + 1'b1;
        else if (fire && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= EMPTY;
            sel_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            sel_q    <= sel_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= index;
    end

`ifdef INDEX_CHECK_EN
    localparam logic [INDEX_TYPE:0] SIZE_W = SIZE[INDEX_TYPE:0];
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (fire && ({1'b0, head} >= SIZE_W)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
